// File: rtl/mem_pkg.sv
// Shared types and constants for the banked 16-bit data memory.
package mem_pkg;

    typedef enum logic {IDLE, SPLIT} state_t;

    localparam int BANK_SEL_BIT = 0;
    localparam int RSP_W        = 16;

endpackage

// File: rtl/ram_bank.sv
// Byte-wide single-port storage bank: synchronous write, registered read.
module ram_bank #(
    parameter int ENTRIES = 393216,
    parameter int AW      = $clog2(ENTRIES)
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] idx,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [ENTRIES];

    // rdata only updates on an enabled access, so it holds across idle cycles
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[idx] <= wdata;
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/word_ram.sv
// 16-bit data memory over even/odd byte banks; odd-address words take two byte cycles.
module word_ram
    import mem_pkg::*;
#(
    parameter int ADDR_W = 20,
    parameter int DEPTH  = 786432
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_word,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              rsp_valid,
    output logic [RSP_W-1:0]  rsp_rdata,
    output logic              rsp_err
);

    localparam int BANK_N  = DEPTH / 2;
    localparam int BANK_AW = $clog2(BANK_N);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    state_t              state;
    logic [ADDR_W-1:0]   hi_addr;
    logic                hi_we;
    logic [7:0]          hi_wdata;
    logic                lo_err;
    logic                lo_rd;
    logic                rsp_lo_en, rsp_lo_odd, rsp_hi_en, rsp_hi_odd;

    logic                en_e, we_e, en_o, we_o;
    logic [BANK_AW-1:0]  idx_e, idx_o;
    logic [7:0]          wd_e, wd_o, q_e, q_o;

    logic [ADDR_W-1:0]   addr_p1;
    logic                fire, odd, in0, in1, in_hi, split_cyc;

    assign addr_p1   = req_addr + ADDR_W'(1);
    assign odd       = req_addr[BANK_SEL_BIT];
    assign in0       = in_range(req_addr);
    assign in1       = in_range(addr_p1);
    assign in_hi     = in_range(hi_addr);
    assign fire      = req_valid && req_ready && (state == IDLE) && !rst;
    assign split_cyc = (state == SPLIT) && !rst;

    // Byte steering: each internal cycle touches each bank at most once
    always_comb begin
        en_e  = 1'b0;
        we_e  = 1'b0;
        en_o  = 1'b0;
        we_o  = 1'b0;
        idx_e = req_addr[BANK_AW:1];
        idx_o = req_addr[BANK_AW:1];
        wd_e  = req_wdata[7:0];
        wd_o  = req_wdata[7:0];
        if (split_cyc) begin
            en_e  = in_hi;
            we_e  = hi_we;
            idx_e = hi_addr[BANK_AW:1];
            wd_e  = hi_wdata;
        end else if (fire) begin
            if (req_word && !odd) begin
                en_e = in0;
                we_e = req_we;
                en_o = in1;
                we_o = req_we;
                wd_o = req_wdata[15:8];
            end else if (odd) begin
                en_o = in0;
                we_o = req_we;
            end else begin
                en_e = in0;
                we_e = req_we;
            end
        end
    end

    ram_bank #(.ENTRIES(BANK_N), .AW(BANK_AW)) u_even (
        .clk(clk), .en(en_e), .we(we_e), .idx(idx_e), .wdata(wd_e), .rdata(q_e)
    );

    ram_bank #(.ENTRIES(BANK_N), .AW(BANK_AW)) u_odd (
        .clk(clk), .en(en_o), .we(we_o), .idx(idx_o), .wdata(wd_o), .rdata(q_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_lo_en  <= 1'b0;
            rsp_lo_odd <= 1'b0;
            rsp_hi_en  <= 1'b0;
            rsp_hi_odd <= 1'b0;
            hi_addr    <= '0;
            hi_we      <= 1'b0;
            hi_wdata   <= '0;
            lo_err     <= 1'b0;
            lo_rd      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_lo_en <= 1'b0;
            rsp_hi_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (fire && req_word && odd) begin
                        state     <= SPLIT;
                        req_ready <= 1'b0;
                        hi_addr   <= addr_p1;
                        hi_we     <= req_we;
                        hi_wdata  <= req_wdata[15:8];
                        lo_err    <= !in0;
                        lo_rd     <= !req_we && in0;
                    end else if (fire) begin
                        rsp_valid  <= 1'b1;
                        rsp_err    <= !in0 || (req_word && !in1);
                        rsp_lo_en  <= !req_we && in0;
                        rsp_lo_odd <= odd;
                        rsp_hi_en  <= !req_we && req_word && in1;
                        rsp_hi_odd <= 1'b1;
                    end
                end
                SPLIT: begin
                    // low byte still sits in the odd bank's read register
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    rsp_valid  <= 1'b1;
                    rsp_err    <= lo_err || !in_hi;
                    rsp_lo_en  <= lo_rd;
                    rsp_lo_odd <= 1'b1;
                    rsp_hi_en  <= !hi_we && in_hi;
                    rsp_hi_odd <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        rsp_rdata = '0;
        if (rsp_lo_en) rsp_rdata[7:0]       = rsp_lo_odd ? q_o : q_e;
        if (rsp_hi_en) rsp_rdata[RSP_W-1:8] = rsp_hi_odd ? q_o : q_e;
    end

endmodule

// File: doc/word_ram.md
# word_ram

Parametrised 16-bit data memory for the 8086 core that replaces the flat byte array. Storage is split into even and odd byte banks, as on the 8086 bus. Aligned byte and word accesses complete in one cycle. Odd-address word accesses are split internally into two byte cycles by a small state machine. Accesses use a valid/ready request channel and a registered response, and sit between the bus interface unit and storage.

## Interface
- `ADDR_W`, 20: byte-address width.
- `DEPTH`, 786432: implemented bytes; must be even. Each bank holds DEPTH/2 bytes.
- `clk`  in  1: clock; all logic on rising edge.
- `rst`  in  1: reset; synchronous, active-high.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: request accepted when valid && ready.
- `req_we`  in  1: 1 = write, 0 = read.
- `req_word`  in  1: 1 = 16-bit access, 0 = byte access.
- `req_addr`  in  ADDR_W: byte address.
- `req_wdata`  in  16: write data; [7:0] is the byte at addr, [15:8] is the byte at addr+1.
- `rsp_valid`  out  1: one-cycle pulse per accepted request, for reads and writes.
- `rsp_rdata`  out  16: read data; byte reads zero-extend into [15:8]; zero for writes.
- `rsp_err`  out  1: valid with rsp_valid; set if any touched byte is at an address ≥ DEPTH.

## Operation
- Bank select: addr[0]=0 selects the even bank, addr[0]=1 the odd bank; bank index = addr >> 1.
- Aligned word (addr[0]=0): even bank gets the low byte, odd bank the high byte, at the same index. One internal cycle.
- Byte access: only the selected bank is accessed. One internal cycle.
- Odd word (addr[0]=1, req_word=1): two internal cycles.
  - Cycle 1: low byte in the odd bank at index addr>>1.
  - Cycle 2: high byte in the even bank at index (addr+1)>>1.
- Address arithmetic is modulo 2^ADDR_W. A word at 0xFFFFF takes its high byte from 0x00000 (8086 wrap).
- Out of range (byte address ≥ DEPTH):
  - write to that byte is dropped;
  - read of that byte returns 0x00;
  - rsp_err=1.
  - The in-range half of a split word still completes normally.
- FSM states:
  - IDLE: req_ready=1. Accepting an odd word goes to SPLIT; all other accepted requests stay in IDLE.
  - SPLIT: req_ready=0. Second byte cycle, then back to IDLE.
- The request is latched on acceptance; inputs may change afterwards.
- Reset mid-SPLIT:
  - return to IDLE and drop the second byte;
  - an already-written first byte stays written;
  - no response is issued.
- Storage contents are not cleared by reset.

## Timing
- Reset values: req_ready=1 (state IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, in the cycle after rst is sampled high. Also with rst held, req_ready=0 is allowed but IDLE must be entered at the first cycle with rst low.
- Aligned/byte request accepted at edge N: write takes effect at N; rsp_valid=1 during the cycle after N (latency 1).
- Odd word accepted at N: SPLIT during N+1; rsp_valid at N+2 (latency 2). Back-to-back throughput is one request per 2 cycles.
- Read-after-write: a read accepted the cycle after a write to the same byte returns the new data. Banks are read-first on the same index only within one internal cycle, which cannot happen since each cycle touches each bank at most once.
- rsp_valid is never held; the consumer has no backpressure.

## Structure
- Shared package `mem_pkg`:
  - state enum {IDLE, SPLIT};
  - constants for bank select bit and response width.
- Sub-module `ram_bank`: byte-wide, DEPTH/2 entries, synchronous write, registered read, single port. Instantiated twice (even, odd).
- FSM, latch registers, range check and byte steering live in word_ram (~200 lines).

## Test plan
- Write word 0x1234 at 0x00100, read word 0x00100 → rsp_rdata=0x1234, latency 1 each, rsp_err=0.
- Write word 0xBEEF at 0x00101 → req_ready low one cycle, response at N+2. Byte reads: 0x00101=0xEF, 0x00102=0xBE.
- Write word 0xA55A at 0xFFFFF with DEPTH=2^20 → 0xFFFFF=0x5A, 0x00000=0xA5.
- DEPTH=786432: read byte 0xC0000 → rsp_rdata=0x0000, rsp_err=1. Word write at 0xBFFFF → low byte stored, rsp_err=1.
- Assert rst during SPLIT of an odd-word write → no rsp_valid, outputs at reset values next cycle, only first byte updated, req_ready=1 afterwards.
- Back-to-back aligned reads at 0x00010/0x00012 held valid → two responses on consecutive cycles with the correct data.
